// File: rtl/mdu_issue_ctrl.sv
// Issue and hazard control for a multi-cycle multiply/divide unit sitting in the E stage.
// Optional stall-cycle performance counter is built only when MDU_STALL_CNT_EN is defined.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_md_valid,
  input  logic [2:0]  e_md_op,
  input  logic        d_md_use,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_we_hi,
  output logic        md_we_lo,
  output logic        busy,
  output logic        md_done,
  output logic        stall_d,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 so that the done cycle lands exactly LAT cycles after start.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic issue_ok_s;
  logic arith_op_s;
  logic md_start_s;
  logic we_hi_s;
  logic we_lo_s;
  logic busy_s;
  logic done_s;
  logic stall_s;
  logic [2:0] md_op_s;

  // Issue decode, strobes and hazard detection.
  always_comb begin
    issue_ok_s = e_md_valid & ~req;
    arith_op_s = ~e_md_op[2];
    md_start_s = issue_ok_s & arith_op_s & (state_q == IDLE);
    we_hi_s    = issue_ok_s & (e_md_op == 3'd4);
    we_lo_s    = issue_ok_s & (e_md_op == 3'd5);
    done_s     = (state_q != IDLE) & (cnt_q == 4'd0);
    busy_s     = md_start_s | (state_q != IDLE);
    stall_s    = d_md_use & busy_s;
    if (md_start_s | we_hi_s | we_lo_s) begin
      md_op_s = e_md_op;
    end else begin
      md_op_s = 3'd0;
    end
  end

  // Next-state and occupancy counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_s) begin
          if (e_md_op[1]) begin
            state_d = DIV;
            cnt_d   = DIV_CNT_INIT;
          end else begin
            state_d = MUL;
            cnt_d   = MUL_CNT_INIT;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      MUL, DIV: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_start = md_start_s;
  assign md_op    = md_op_s;
  assign md_we_hi = we_hi_s;
  assign md_we_lo = we_lo_s;
  assign busy     = busy_s;
  assign md_done  = done_s;
  assign stall_d  = stall_s;

`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running stall counter; wraps naturally at 32 bits.
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed self-checking bench for mdu_issue_ctrl; inputs change 1ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_mdu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        e_md_valid;
  logic [2:0]  e_md_op;
  logic        d_md_use;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_we_hi;
  logic        md_we_lo;
  logic        busy;
  logic        md_done;
  logic        stall_d;
  logic [31:0] stall_cycles;

  int checks;
  int failures;
  logic [31:0] exp_sc;

  mdu_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .e_md_valid   (e_md_valid),
    .e_md_op      (e_md_op),
    .d_md_use     (d_md_use),
    .md_start     (md_start),
    .md_op        (md_op),
    .md_we_hi     (md_we_hi),
    .md_we_lo     (md_we_lo),
    .busy         (busy),
    .md_done      (md_done),
    .stall_d      (stall_d),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, then check every output against the hand-written expectation.
  task automatic cyc(input string tag, input int k,
                     input logic v, input logic [2:0] op, input logic r, input logic du, input logic rs,
                     input logic e_start, input logic e_busy, input logic e_done, input logic e_stall,
                     input logic e_hi, input logic e_lo, input logic [2:0] e_op);
    string t;
    @(posedge clk);
    #1;
    e_md_valid = v;
    e_md_op    = op;
    req        = r;
    d_md_use   = du;
    reset      = rs;
    @(negedge clk);
    t = $sformatf("%s[%0d]", tag, k);
    check_eq({t, ".md_start"}, {31'd0, md_start}, {31'd0, e_start});
    check_eq({t, ".busy"},     {31'd0, busy},     {31'd0, e_busy});
    check_eq({t, ".md_done"},  {31'd0, md_done},  {31'd0, e_done});
    check_eq({t, ".stall_d"},  {31'd0, stall_d},  {31'd0, e_stall});
    check_eq({t, ".md_we_hi"}, {31'd0, md_we_hi}, {31'd0, e_hi});
    check_eq({t, ".md_we_lo"}, {31'd0, md_we_lo}, {31'd0, e_lo});
    check_eq({t, ".md_op"},    {29'd0, md_op},    {29'd0, e_op});
    check_eq({t, ".stall_cycles"}, stall_cycles, exp_sc);
`ifdef MDU_STALL_CNT_EN
    if (rs) exp_sc = 32'd0;
    else if (e_stall) exp_sc = exp_sc + 32'd1;
    else exp_sc = exp_sc;
`endif
  endtask

  task automatic idle_cyc(input string tag, input int k);
    cyc(tag, k, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic reset_cyc(input string tag);
    cyc(tag, 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_sc     = 32'd0;
    reset      = 1'b1;
    req        = 1'b0;
    e_md_valid = 1'b0;
    e_md_op    = 3'd0;
    d_md_use   = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state with quiet inputs.
    idle_cyc("rst_state", 0);
    idle_cyc("rst_state", 1);

    // mult with D-stage consumer held: start@0, done@5, stall 0..5, idle@6.
    for (int k = 0; k <= 6; k++)
      cyc("mult", k, k == 0, 3'd0, 1'b0, 1'b1, 1'b0,
          k == 0, k <= 5, k == 5, k <= 5, 1'b0, 1'b0, 3'd0);
    idle_cyc("mult_tail", 0);

    // divu with D-stage consumer held: done@10, busy 0..10, 11 stall cycles.
    reset_cyc("pre_divu");
    for (int k = 0; k <= 11; k++)
      cyc("divu", k, k == 0, 3'd3, 1'b0, 1'b1, 1'b0,
          k == 0, k <= 10, k == 10, k <= 10, 1'b0, 1'b0, (k == 0) ? 3'd3 : 3'd0);
`ifdef MDU_STALL_CNT_EN
    check_eq("divu.stall_total", stall_cycles, 32'd11);
`else
    check_eq("divu.stall_total", stall_cycles, 32'd0);
`endif

    // div flushed in its E cycle: nothing starts, nothing completes.
    cyc("div_flush", 0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 1; k <= 11; k++) idle_cyc("div_flush", k);

    // mult with a flush two cycles later still completes on schedule.
    for (int k = 0; k <= 6; k++)
      cyc("mult_req", k, k == 0, 3'd0, k == 2, 1'b0, 1'b0,
          k == 0, k <= 5, k == 5, 1'b0, 1'b0, 1'b0, 3'd0);

    // Back-to-back: multu issued the cycle after md_done of a mult.
    for (int k = 0; k <= 12; k++)
      cyc("b2b", k, (k == 0) || (k == 6), (k == 6) ? 3'd1 : 3'd0, 1'b0, 1'b0, 1'b0,
          (k == 0) || (k == 6), k <= 11, (k == 5) || (k == 11), 1'b0, 1'b0, 1'b0,
          (k == 6) ? 3'd1 : 3'd0);

    // Move-to strobes and move-from ops.
    cyc("mthi", 0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);
    idle_cyc("mthi", 1);
    cyc("mthi_req", 0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    cyc("mtlo", 0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    cyc("mfhi", 0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    cyc("mflo", 0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // mtlo strobes while a mult is in flight; a second mult in E is ignored.
    for (int k = 0; k <= 6; k++)
      cyc("mt_busy", k, (k == 0) || (k == 2) || (k == 3), (k == 2) ? 3'd5 : 3'd0, 1'b0, 1'b0, 1'b0,
          k == 0, k <= 5, k == 5, 1'b0, 1'b0, k == 2, (k == 2) ? 3'd5 : 3'd0);

    // div abandoned by reset at 3; mult at 5 completes at 10.
    for (int k = 0; k <= 11; k++)
      cyc("div_rst", k, (k == 0) || (k == 5), (k == 0) ? 3'd2 : 3'd0, 1'b0, 1'b0, k == 3,
          (k == 0) || (k == 5), (k <= 3) || ((k >= 5) && (k <= 10)), k == 10, 1'b0,
          1'b0, 1'b0, (k == 0) ? 3'd2 : 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 5: cycles a mult/multu occupies the MDU after its start cycle.
REQ-002 Parameter DIV_LAT, default 10: cycles a div/divu occupies the MDU after its start cycle.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  exception/interrupt flush of the E-stage instruction.
REQ-006 e_md_valid  input  1  E-stage instruction is an MDU instruction.
REQ-007 e_md_op  input  3  E-stage op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
REQ-008 d_md_use  input  1  D-stage instruction is any MDU instruction (ops 0-7).
REQ-009 md_start  output  1  one-cycle start strobe to the MDU.
REQ-010 md_op  output  3  op presented to the MDU; equals e_md_op when md_start, md_we_hi or md_we_lo is high, else 0.
REQ-011 md_we_hi  output  1  HI write strobe for mthi; md_we_lo  output  1  LO write strobe for mtlo.
REQ-012 busy  output  1  MDU occupied or being started this cycle.
REQ-013 md_done  output  1  one-cycle pulse in the last occupied cycle; HI/LO valid from the next cycle.
REQ-014 stall_d  output  1  hold the D stage and insert a bubble into E.
REQ-015 stall_cycles  output  32  count of cycles with stall_d high.

Function
REQ-016 States: IDLE, MUL, DIV; 4-bit down-counter cnt.
REQ-017 md_start = e_md_valid & ~req & (e_md_op <= 3) & (state == IDLE); combinational.
REQ-018 On md_start: ops 0-1 -> MUL with cnt = MUL_LAT-1; ops 2-3 -> DIV with cnt = DIV_LAT-1.
REQ-019 In MUL/DIV: cnt > 0 -> decrement; cnt == 0 -> md_done = 1 and return to IDLE at the next edge.
REQ-020 Start accepted in cycle T -> md_done in cycle T+LAT; busy high T through T+LAT, low at T+LAT+1.
REQ-021 busy = md_start | (state != IDLE).
REQ-022 md_we_hi = e_md_valid & ~req & (e_md_op == 4); md_we_lo likewise for op 5; both are independent of state.
REQ-023 Ops 6-7 in E produce no strobes.
REQ-024 stall_d = d_md_use & busy; D-stage mfhi/mflo/mt*/mult/div never advance while an op is in flight or starting.
REQ-025 req in the start cycle suppresses md_start, md_we_hi and md_we_lo; state stays IDLE.
REQ-026 req while in MUL/DIV does not abort: the in-flight op completes and md_done pulses on schedule.
REQ-027 An op 0-3 in E while state != IDLE is ignored; cannot occur given REQ-024.
REQ-028 An op issued in the cycle right after md_done is accepted with no gap cycle.
REQ-029 Pipeline hand-off: with E start at T and a D-stage mfhi at T, stall_d is high T through T+LAT and low at T+LAT+1.

Reset
REQ-030 On reset: state = IDLE, cnt = 0, stall_cycles = 0; md_start, md_we_hi, md_we_lo, md_done and stall_d follow from their inputs with busy = 0 from the next cycle.
REQ-031 reset mid-operation abandons the op: no md_done, busy low in the cycle after reset.

Configuration
REQ-032 Macro MDU_STALL_CNT_EN defined: stall_cycles increments by 1 each cycle stall_d = 1, wraps 0xFFFFFFFF -> 0, clears on reset.
REQ-033 Macro MDU_STALL_CNT_EN undefined: stall_cycles is tied to 0 and no counter register exists; all other behaviour is identical.

Verification
REQ-034 Bench: mult at T=10, d_md_use=1 from T=10 -> md_start@10, md_done@15, stall_d high 10-15, busy low @16.
REQ-035 Bench: divu at T=10 -> md_done@20, busy high 10-20; with MDU_STALL_CNT_EN and d_md_use held, stall_cycles = 11.
REQ-036 Bench: div with req=1 in its E cycle -> md_start = 0, busy = 0, no md_done.
REQ-037 Bench: mult at T, req=1 at T+2 -> md_done still @T+5.
REQ-038 Bench: mthi with req=0 -> md_we_hi = 1 and md_op = 4 for 1 cycle; mthi with req=1 -> no strobe.
REQ-039 Bench: div at T, reset at T+3 -> busy = 0 @T+4, no md_done; mult at T+5 -> md_done @T+10.
